uart_frame_echo: RTL

Frame-level command handler between the UART receive and launch paths of the UART system.
- Drains received bytes from the receive RAM and parses frames of the form `0xA5`, LEN, payload, checksum.
- Validates each frame and writes a response frame into the launch RAM, then holds the launch enable until the launcher has sent it.
- Gives the design a working loopback and command front end without host software.

---
 rtl/uart_frame_pkg.sv | 36 +++
 rtl/uart_frame_echo_timeout_cnt.sv | 30 +++
 rtl/uart_frame_echo.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_pkg.sv
// Purpose: shared types and constants for the UART frame echo block.
// Latency: n/a (types, constants and a length-check helper only).
// Backpressure: n/a.
package uart_frame_pkg;

    // Top-level sequencing: byte fetch pipeline, response write, launch wait.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_PARSE,
        ST_WRITE,
        ST_LAUNCH
    } state_t;

    // Which field of the frame the next parsed byte belongs to.
    typedef enum logic [1:0] {
        PH_HDR,
        PH_LEN,
        PH_PAY,
        PH_CSUM
    } phase_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

    // A LEN byte is acceptable when it is 1..max_len.
    function automatic logic len_ok(input logic [7:0] len, input int unsigned max_len);
        return (len != 8'd0) && (32'(len) <= max_len);
    endfunction

endpackage

// File: rtl/uart_frame_echo_timeout_cnt.sv
// Purpose: idle-cycle watchdog; counts while run is high, flags expiry at TIMEOUT_CYCLES.
// Latency: expired rises the cycle after the TIMEOUT_CYCLES-th counted cycle.
// Backpressure: none; saturates at the limit until cleared.
// Ports: clk, reset (sync, active-high), clear (zero the count), run (count enable), expired.
module frame_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_q <= '0;
        end else if (run && !expired) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/uart_frame_echo.sv
// Purpose: parse A5/LEN/payload/checksum frames from the receive RAM and echo valid ones to the launch RAM.
// Latency: 3 cycles per received byte; writes start the cycle after the checksum byte, launch the cycle after the last write.
// Backpressure: bytes stay in the receive RAM while writing/launching; launch waits on the launcher counter with a timeout.
// Ports: receive RAM read side (address counter, read address/data), launch RAM write side
//        (en_write, address, data), launcher handshake (en_launch, launch_address_counter),
//        status (busy_o, frame_ok_o, frame_err_o, err_code_o).
module uart_frame_echo
    import uart_frame_pkg::*;
#(
    parameter logic [7:0]  HEADER         = HEADER_DEFAULT,
    parameter int unsigned MAX_LEN        = 16,
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
    input  logic       CLK100MHZ,
    input  logic       reset,
    input  logic [7:0] receive_address_counter,
    output logic [7:0] receive_read_address,
    input  logic [7:0] receive_read_data,
    output logic       en_write,
    output logic [7:0] launch_write_address,
    output logic [7:0] launch_write_data,
    output logic       en_launch,
    input  logic [7:0] launch_address_counter,
    output logic       busy_o,
    output logic       frame_ok_o,
    output logic       frame_err_o,
    output logic [1:0] err_code_o
);

    localparam int unsigned IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    state_t     state_q, state_d;
    phase_t     phase_q, phase_d;

    logic [7:0] rd_ptr_q;
    logic [7:0] len_q;
    logic [7:0] sum_q;
    logic [7:0] idx_q;
    logic [7:0] widx_q;
    logic [7:0] pay_buf [MAX_LEN];

    logic       consume;
    logic       err_evt;
    logic [1:0] err_code_d;
    logic       launch_done;
    logic       to_expired;
    logic       to_run;
    logic       to_clear;
    logic       byte_avail;
    logic       more_after;
    logic [IW-1:0] pay_rd_idx;

    // Pointers are compared mod 256, so the 255->0 wrap needs no special case.
    assign byte_avail = (rd_ptr_q != receive_address_counter);
    assign more_after = ((rd_ptr_q + 8'd1) != receive_address_counter);

    // The timer measures gaps between bytes inside a frame and the launch duration.
    assign to_run   = ((state_q == ST_IDLE) && (phase_q != PH_HDR)) || (state_q == ST_LAUNCH);
    assign to_clear = consume || (state_q == ST_WRITE) ||
                      ((state_q == ST_IDLE) && (phase_q == PH_HDR));

    frame_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (CLK100MHZ),
        .reset   (reset),
        .clear   (to_clear),
        .run     (to_run),
        .expired (to_expired)
    );

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state_q <= ST_IDLE;
            phase_q <= PH_HDR;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        consume     = 1'b0;
        err_evt     = 1'b0;
        err_code_d  = ERR_NONE;
        launch_done = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if ((phase_q != PH_HDR) && to_expired) begin
                    err_evt    = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    phase_d    = PH_HDR;
                end else if (byte_avail) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT:  state_d = ST_PARSE;
            ST_PARSE: begin
                consume = 1'b1;
                state_d = more_after ? ST_FETCH : ST_IDLE;
                case (phase_q)
                    PH_HDR: begin
                        if (receive_read_data == HEADER) phase_d = PH_LEN;
                    end
                    PH_LEN: begin
                        if (len_ok(receive_read_data, MAX_LEN)) begin
                            phase_d = PH_PAY;
                        end else begin
                            err_evt    = 1'b1;
                            err_code_d = ERR_LEN;
                            phase_d    = PH_HDR;
                        end
                    end
                    PH_PAY: begin
                        if (idx_q == (len_q - 8'd1)) phase_d = PH_CSUM;
                    end
                    PH_CSUM: begin
                        phase_d = PH_HDR;
                        if (receive_read_data == sum_q) begin
                            state_d = ST_WRITE;
                        end else begin
                            err_evt    = 1'b1;
                            err_code_d = ERR_CSUM;
                        end
                    end
                    default: phase_d = PH_HDR;
                endcase
            end
            ST_WRITE: begin
                if (widx_q == (len_q + 8'd2)) state_d = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                if (launch_address_counter == (len_q + 8'd3)) begin
                    launch_done = 1'b1;
                    state_d     = ST_IDLE;
                end else if (to_expired) begin
                    err_evt    = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = PH_HDR;
            end
        endcase
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            rd_ptr_q    <= 8'd0;
            len_q       <= 8'd0;
            sum_q       <= 8'd0;
            idx_q       <= 8'd0;
            widx_q      <= 8'd0;
            frame_err_o <= 1'b0;
            err_code_o  <= ERR_NONE;
        end else begin
            if (consume) rd_ptr_q <= rd_ptr_q + 8'd1;

            if (state_q == ST_PARSE) begin
                if (phase_q == PH_LEN) begin
                    // The length seeds the running checksum.
                    len_q <= receive_read_data;
                    sum_q <= receive_read_data;
                    idx_q <= 8'd0;
                end else if (phase_q == PH_PAY) begin
                    sum_q <= sum_q + receive_read_data;
                    idx_q <= idx_q + 8'd1;
                end
            end

            widx_q <= (state_q == ST_WRITE) ? (widx_q + 8'd1) : 8'd0;

            frame_err_o <= err_evt;
            if (err_evt) begin
                err_code_o <= err_code_d;
            end else if (launch_done) begin
                err_code_o <= ERR_NONE;
            end
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if ((state_q == ST_PARSE) && (phase_q == PH_PAY)) begin
            pay_buf[IW'(idx_q)] <= receive_read_data;
        end
    end

    // Response layout: HEADER, LEN, payload[0..LEN-1], checksum.
    assign pay_rd_idx = IW'(widx_q - 8'd2);

    always_comb begin
        en_write             = 1'b0;
        launch_write_address = 8'd0;
        launch_write_data    = 8'd0;
        if (state_q == ST_WRITE) begin
            en_write             = 1'b1;
            launch_write_address = widx_q;
            if (widx_q == 8'd0) begin
                launch_write_data = HEADER;
            end else if (widx_q == 8'd1) begin
                launch_write_data = len_q;
            end else if (widx_q == (len_q + 8'd2)) begin
                launch_write_data = sum_q;
            end else begin
                launch_write_data = pay_buf[pay_rd_idx];
            end
        end
    end

    assign receive_read_address = rd_ptr_q;
    assign en_launch            = (state_q == ST_LAUNCH);
    assign frame_ok_o           = launch_done;
    assign busy_o               = (state_q == ST_WRITE) || (state_q == ST_LAUNCH) || (phase_q != PH_HDR);

endmodule
